// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: tick divider, BCD mm:ss.cc counter and IDLE/RUN/PAUSE control.
// Define STOPWATCH_LAP_EN to compile in the LAP state with its frozen display register.
module stopwatch_ctrl #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       key_ss,
  input  logic       key_clr,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] cs_t,
  output logic [3:0] cs_o,
  output logic       running,
  output logic       ovf
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
`ifdef STOPWATCH_LAP_EN
  localparam logic [1:0] ST_LAP   = 2'd3;
`endif

  // Digit order, MSB first: min_t, min_o, sec_t, sec_o, cs_t, cs_o. Bit 24 flags a wrap.
  function automatic logic [24:0] bcd_inc(input logic [23:0] c);
    logic [23:0] n;
    logic        cy;
    logic [3:0]  lim;
    n  = c;
    cy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
      if (cy) begin
        if (c[i*4 +: 4] >= lim) begin
          n[i*4 +: 4] = 4'd0;
        end else begin
          n[i*4 +: 4] = c[i*4 +: 4] + 4'd1;
          cy          = 1'b0;
        end
      end else begin
        n[i*4 +: 4] = c[i*4 +: 4];
      end
    end
    return {cy, n};
  endfunction

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [23:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          running_q, running_d;
  logic          active_s, tick_s, clr_all_s;
  logic [24:0]   inc_s;
  logic [23:0]   disp_s;

  // Control FSM next state; key_ss takes priority over key_clr.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (key_ss) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (key_ss)       state_d = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (key_clr) state_d = ST_LAP;
`endif
        else              state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (key_ss)       state_d = ST_RUN;
        else if (key_clr) state_d = ST_IDLE;
        else              state_d = ST_PAUSE;
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (key_ss)       state_d = ST_PAUSE;
        else if (key_clr) state_d = ST_RUN;
        else              state_d = ST_LAP;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef STOPWATCH_LAP_EN
  assign active_s = (state_q == ST_RUN) || (state_q == ST_LAP);
`else
  assign active_s = (state_q == ST_RUN);
`endif
  assign tick_s    = active_s && (div_q == DIV_LAST);
  assign clr_all_s = (state_q == ST_PAUSE) && (state_d == ST_IDLE);
  assign inc_s     = bcd_inc(cnt_q);

  // Divider, count, overflow and running flag next values.
  always_comb begin
    if (clr_all_s) begin
      div_d = '0;
    end else if (active_s) begin
      div_d = tick_s ? '0 : div_q + DW'(1);
    end else if (state_q == ST_IDLE) begin
      div_d = '0;
    end else begin
      div_d = div_q;
    end

    if (clr_all_s)   cnt_d = 24'd0;
    else if (tick_s) cnt_d = inc_s[23:0];
    else             cnt_d = cnt_q;

    if (clr_all_s)                 ovf_d = 1'b0;
    else if (tick_s && inc_s[24]) ovf_d = 1'b1;
    else                           ovf_d = ovf_q;

`ifdef STOPWATCH_LAP_EN
    running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
`else
    running_d = (state_d == ST_RUN);
`endif
  end

  // Main state registers.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      cnt_q     <= 24'd0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [23:0] disp_q, disp_d;

  // While in LAP the display keeps the count seen on LAP entry.
  always_comb begin
    if (state_d == ST_LAP) disp_d = disp_q;
    else                   disp_d = cnt_d;
  end

  // Display freeze register.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) disp_q <= 24'd0;
    else         disp_q <= disp_d;
  end

  assign disp_s = disp_q;
`else
  assign disp_s = cnt_q;
`endif

  assign {min_t, min_o, sec_t, sec_o, cs_t, cs_o} = disp_s;
  assign running = running_q;
  assign ovf     = ovf_q;

endmodule
